spi_bus_arbiter: RTL and testbench
==================================

SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The module SHALL have parameter DATA_WIDTH, default 8, giving the SPI word width.
REQ-003 The module SHALL have parameter TIMEOUT, default 255, giving the maximum number of cycles to wait for m_busy after m_start.
REQ-004 The module SHALL have these ports, one per line (name  direction  width  meaning):
  clk  in  1  system clock, all logic on rising edge
  rst  in  1  reset, asynchronous, active-high
  req  in  NUM_REQ  per-requester transfer request, level
  req_data  in  NUM_REQ*DATA_WIDTH  tx word; requester i on bits [i*DATA_WIDTH +: DATA_WIDTH]
  gnt  out  NUM_REQ  one-hot grant to the current owner
  done  out  NUM_REQ  one-cycle completion pulse to the owner
  err  out  1  qualifies done: 1 = transfer timed out
  rsp_data  out  DATA_WIDTH  received word, valid with done
  m_start  out  1  start pulse to the shared SPI master
  m_data_in  out  DATA_WIDTH  tx word to the master
  m_data_out  in  DATA_WIDTH  rx word from the master
  m_busy  in  1  master transfer in progress
  m_cs  in  1  master chip select, active-low
  cs_n  out  NUM_REQ  per-slave chip selects, active-low

Function
REQ-005 The FSM SHALL have states IDLE, START, WAIT_BUSY, WAIT_DONE and RESP.
REQ-006 In IDLE with req != 0, the block SHALL select the first set req bit searching circularly from last_owner+1, latch owner and req_data slice, and move to START.
REQ-007 In IDLE with req == 0, the block SHALL remain in IDLE with all outputs inactive.
REQ-008 In START, m_start SHALL be 1 for exactly one cycle, and the block SHALL move to WAIT_BUSY.
REQ-009 In WAIT_BUSY, m_busy=1 SHALL cause a move to WAIT_DONE.
REQ-010 In WAIT_BUSY, if TIMEOUT cycles elapse without m_busy=1, the block SHALL move to RESP with err=1.
REQ-011 In WAIT_DONE, m_busy=0 SHALL capture m_data_out into rsp_data and cause a move to RESP.
REQ-012 WAIT_DONE SHALL have no timeout.
REQ-013 In RESP, done[owner] SHALL be 1 for one cycle, err SHALL be valid in that cycle, last_owner SHALL be set to owner, and the block SHALL return to IDLE.
REQ-014 m_data_in SHALL hold the latched word from START through RESP.
REQ-015 gnt[owner] SHALL be 1 from START through RESP inclusive, and gnt SHALL be 0 otherwise.
REQ-016 cs_n[i] SHALL equal m_cs when i == owner and gnt != 0, and SHALL be 1 otherwise.
REQ-017 Deassertion of req[owner] after START SHALL NOT abort the transfer; the transfer SHALL complete and done SHALL still pulse.
REQ-018 A requester still asserting req after its done pulse SHALL be re-arbitrated in the following IDLE cycle at lowest priority.
REQ-019 Minimum transfer-to-transfer spacing SHALL be one IDLE cycle after RESP.
REQ-020 req_data changes after latching SHALL have no effect on the current transfer.
REQ-021 The timeout counter SHALL be ceil(log2(TIMEOUT+1)) bits, cleared on entry to WAIT_BUSY, and SHALL NOT wrap.

Reset
REQ-022 When rst=1, the block SHALL immediately force state=IDLE, owner=0, last_owner=NUM_REQ-1 (so requester 0 wins first), gnt=0, done=0, err=0, m_start=0, m_data_in=0, rsp_data=0, cs_n=all 1, and timeout counter=0.
REQ-023 Reset asserted mid-transfer SHALL drop gnt and cs_n to the inactive state the same cycle and SHALL produce no done pulse; resetting the master is the integrator's responsibility.

Verification
REQ-024 The bench SHALL cover: req=0100, req_data[2]=0xA5, master model loops MOSI->MISO -> m_start pulse 1 cycle after req, cs_n=1011 while m_cs=0, done=0100 pulse, rsp_data=0xA5, err=0.
REQ-025 The bench SHALL cover: req=1111 held constant over 8 transfers from reset -> grant order 0,1,2,3,0,1,2,3, with exactly one done per grant.
REQ-026 The bench SHALL cover: req=0001 with m_busy tied 0, TIMEOUT=10 -> done=0001 with err=1 exactly 10 cycles after WAIT_BUSY entry, then return to IDLE.
REQ-027 The bench SHALL cover: req[1] dropped and req_data[1] changed 0x3C->0xFF during WAIT_DONE -> transfer completes, m_data_in stays 0x3C, done[1] pulses.
REQ-028 The bench SHALL cover: rst asserted in WAIT_DONE -> gnt=0, cs_n=1111 and done=0 immediately; after release with req=1000, requester 3 is granted.
REQ-029 The bench SHALL cover: simultaneous req=0110 with last_owner=2 -> requester 1 granted first, requester 2 second.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters.
// Owner and tx word are latched at grant; a missing m_busy times out.
module spi_bus_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic                          err,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          m_start,
  output logic [DATA_WIDTH-1:0]         m_data_in,
  input  logic [DATA_WIDTH-1:0]         m_data_out,
  input  logic                          m_busy,
  input  logic                          m_cs,
  output logic [NUM_REQ-1:0]            cs_n
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } state_t;

  state_t                state_q, state_d;
  logic [OW-1:0]         owner_q, owner_d;
  logic [OW-1:0]         last_q, last_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic [OW-1:0]         pick;
  logic                  found;
  logic [NUM_REQ-1:0]    oh;
  logic                  active;

  // Circular search starting just after the previous owner
  always_comb begin
    int c;
    c     = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = int'(last_q) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!found && req[c]) begin
        found = 1'b1;
        pick  = OW'(c);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = pick;
          tx_d    = req_data[pick*DATA_WIDTH +: DATA_WIDTH];
          err_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (m_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (cnt_q != CW'(TIMEOUT)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!m_busy) begin
          rx_d    = m_data_out;
          state_d = RESP;
        end
      end
      RESP: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= OW'(NUM_REQ - 1);
      tx_q    <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode from state so reset drops them the same cycle
  assign active    = (state_q != IDLE);
  assign oh        = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
  assign gnt       = active ? oh : '0;
  assign done      = (state_q == RESP) ? oh : '0;
  assign err       = (state_q == RESP) && err_q;
  assign m_start   = (state_q == START);
  assign m_data_in = tx_q;
  assign rsp_data  = rx_q;
  assign cs_n      = active ? ~(oh & {NUM_REQ{~m_cs}}) : '1;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Randomized bench for spi_bus_arbiter against a round-robin model.
// The bench plays the SPI master procedurally, cycle by cycle.
module tb_spi_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        err;
  logic [7:0]  rsp_data;
  logic        m_start;
  logic [7:0]  m_data_in;
  logic [7:0]  m_data_out;
  logic        m_busy;
  logic        m_cs;
  logic [3:0]  cs_n;

  int vectors     = 0;
  int miscompares = 0;
  int mlast;

  spi_bus_arbiter #(
    .NUM_REQ(4),
    .DATA_WIDTH(8),
    .TIMEOUT(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .gnt(gnt),
    .done(done),
    .err(err),
    .rsp_data(rsp_data),
    .m_start(m_start),
    .m_data_in(m_data_in),
    .m_data_out(m_data_out),
    .m_busy(m_busy),
    .m_cs(m_cs),
    .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] rq,
                              input int last);
    for (int k = 1; k <= 4; k++)
      if (rq[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  // dly < 0: master never raises m_busy
  task automatic xfer(input logic [3:0] rq,
                      input int dly,
                      input int len,
                      input bit perturb,
                      input logic [7:0] nw,
                      input logic [7:0] rx);
    int own;
    logic [7:0] w;
    logic [3:0] oh;
    logic [3:0] ncs;
    req = rq;
    own = pick(rq, mlast);
    w   = req_data[own*8 +: 8];
    oh  = 4'b0001 << own;
    ncs = ~oh;
    @(posedge clk); #1;
    chk("start", m_start, 1);
    chk("gnt", gnt, oh);
    chk("mdi", m_data_in, w);
    chk("done_early", done, 0);
    @(posedge clk); #1;
    chk("start_pulse", m_start, 0);
    if (dly < 0) begin
      repeat (9) begin @(posedge clk); #1; end
      chk("to_early", done, 0);
      @(posedge clk); #1;
      chk("to_done", done, oh);
      chk("to_err", err, 1);
      chk("to_gnt", gnt, oh);
    end else begin
      repeat (dly) begin @(posedge clk); #1; end
      m_busy = 1'b1;
      m_cs   = 1'b0;
      @(posedge clk); #1;
      chk("cs_n", cs_n, ncs);
      if (perturb) begin
        req[own]            = 1'b0;
        req_data[own*8 +: 8] = nw;
      end
      repeat (len) begin
        @(posedge clk); #1;
        chk("hold_mdi", m_data_in, w);
        chk("hold_done", done, 0);
      end
      m_busy     = 1'b0;
      m_cs       = 1'b1;
      m_data_out = rx;
      @(posedge clk); #1;
      chk("done", done, oh);
      chk("err", err, 0);
      chk("rsp", rsp_data, rx);
      chk("resp_gnt", gnt, oh);
      chk("resp_cs", cs_n, 4'hf);
    end
    mlast = own;
    @(posedge clk); #1;
    chk("idle_gnt", gnt, 0);
    chk("idle_done", done, 0);
    chk("idle_start", m_start, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    req        = '0;
    req_data   = '0;
    m_busy     = 1'b0;
    m_cs       = 1'b1;
    m_data_out = '0;
    mlast      = 3;
    #12;
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_start", m_start, 0);
    chk("rst_mdi", m_data_in, 0);
    chk("rst_rsp", rsp_data, 0);
    chk("rst_cs", cs_n, 4'hf);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("idle_noreq", gnt, 0);
    chk("idle_nostart", m_start, 0);

    req_data = $urandom;
    for (int i = 0; i < 8; i++)
      xfer(4'hf, $urandom_range(0, 5), $urandom_range(1, 4),
           1'b0, 8'h00, 8'($urandom));

    req_data[23:16] = 8'hA5;
    xfer(4'b0100, 2, 3, 1'b0, 8'h00, 8'hA5);

    req_data = $urandom;
    xfer(4'b0110, 1, 1, 1'b0, 8'h00, 8'h5A);
    xfer(4'b0110, 0, 2, 1'b0, 8'h00, 8'h3C);

    xfer(4'b0001, -1, 1, 1'b0, 8'h00, 8'h00);

    req_data[15:8] = 8'h3C;
    xfer(4'b0010, 1, 2, 1'b1, 8'hFF, 8'h77);

    for (int i = 0; i < 40; i++) begin
      int dly;
      req_data = $urandom;
      dly = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, 5);
      xfer(4'($urandom_range(1, 15)), dly, $urandom_range(1, 4),
           1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end

    req = 4'b0100;
    @(posedge clk);
    @(posedge clk); #1;
    m_busy = 1'b1;
    m_cs   = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_cs", cs_n, 4'hf);
    chk("mid_rst_done", done, 0);
    m_busy = 1'b0;
    m_cs   = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    mlast = 3;
    req_data[31:24] = 8'h96;
    xfer(4'b1000, 1, 1, 1'b0, 8'h00, 8'h69);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
